// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB request queue.
// Holds FSM encoding, default bus widths and request-entry width.
package apb_pkg;

  localparam int DEF_ADDR_SIZE = 32;
  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_PROT_SIZE = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic int entry_w(
    input int a,
    input int d,
    input int p
  );
    return 1 + p + a + d + d / 8;
  endfunction

  localparam int ENTRY_W =
    entry_w(DEF_ADDR_SIZE, DEF_DATA_SIZE, DEF_PROT_SIZE);

endpackage

// File: rtl/apb_sync_fifo.sv
// In-order request storage: push/pop, head and next-head views.
// Ports: clk, rst_n, push, pop, din, head, head_nxt, count, full, empty.
module apb_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [W-1:0]     head_nxt,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] CAP = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] rptr_inc;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CAP);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign rptr_inc = rptr + 1'b1;
  assign head     = mem[rptr];
  assign head_nxt = mem[rptr_inc];

  // Storage needs no reset: entries are only read when counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr_inc;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_req_queue.sv
// CPU-to-APB request queue: buffers requests, issues one at a time.
// Ports: CREQ_* in, CRSP_* out, M* bus request/complete, COUNT.
module apb_req_queue
  import apb_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int PROT_SIZE = DEF_PROT_SIZE,
  parameter int STRB_SIZE = DATA_SIZE / 8,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 CREQ_VALID,
  output logic                 CREQ_READY,
  input  logic                 CWRITE,
  input  logic [PROT_SIZE-1:0] CPROT,
  input  logic [ADDR_SIZE-1:0] CADDR,
  input  logic [DATA_SIZE-1:0] CWDATA,
  input  logic [STRB_SIZE-1:0] CSTRB,
  output logic                 CRSP_VALID,
  output logic                 CRSP_WRITE,
  output logic [DATA_SIZE-1:0] CRDATA,
  output logic                 CSLVERR,
  output logic                 MSTART,
  output logic                 MWRITE,
  output logic [PROT_SIZE-1:0] MPROT,
  output logic [ADDR_SIZE-1:0] MADDR,
  output logic [DATA_SIZE-1:0] MWDATA,
  output logic [STRB_SIZE-1:0] MSTRB,
  input  logic                 MDONE,
  input  logic [DATA_SIZE-1:0] MRDATA,
  input  logic                 MSLVERR,
  output logic [PTR_W:0]       COUNT
);

  localparam int EW =
    1 + PROT_SIZE + ADDR_SIZE + DATA_SIZE + STRB_SIZE;
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  state_t          state;
  logic [EW-1:0]   din;
  logic [EW-1:0]   head;
  logic [EW-1:0]   head_nxt;
  logic [EW-1:0]   sel;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            more;

  logic                 s_write;
  logic [PROT_SIZE-1:0] s_prot;
  logic [ADDR_SIZE-1:0] s_addr;
  logic [DATA_SIZE-1:0] s_wdata;
  logic [STRB_SIZE-1:0] s_strb;

  assign CREQ_READY = PRESETn & ~full;
  assign push       = CREQ_VALID & CREQ_READY;
  assign pop        = (state == ST_WAIT) & MDONE;
  assign din        = {CWRITE, CPROT, CADDR, CWDATA, CSTRB};

  // After a pop the new head is the second entry, or the
  // request being pushed right now when only one was held.
  assign more = (COUNT > CNT_ONE) | push;

  always_comb begin
    sel = head;
    if (state == ST_WAIT)
      sel = (COUNT > CNT_ONE) ? head_nxt : din;
  end

  assign {s_write, s_prot, s_addr, s_wdata, s_strb} = sel;

  apb_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .head     (head),
    .head_nxt (head_nxt),
    .count    (COUNT),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= ST_IDLE;
      MSTART     <= 1'b0;
      MWRITE     <= 1'b0;
      MPROT      <= '0;
      MADDR      <= '0;
      MWDATA     <= '0;
      MSTRB      <= '0;
      CRSP_VALID <= 1'b0;
      CRSP_WRITE <= 1'b0;
      CRDATA     <= '0;
      CSLVERR    <= 1'b0;
    end else begin
      MSTART     <= 1'b0;
      CRSP_VALID <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            MWRITE <= s_write;
            MPROT  <= s_prot;
            MADDR  <= s_addr;
            MWDATA <= s_wdata;
            MSTRB  <= s_strb;
            MSTART <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (MDONE) begin
            CRSP_VALID <= 1'b1;
            CRSP_WRITE <= MWRITE;
            CSLVERR    <= MSLVERR;
            CRDATA     <= MWRITE ? '0 : MRDATA;
            if (more) begin
              MWRITE <= s_write;
              MPROT  <= s_prot;
              MADDR  <= s_addr;
              MWDATA <= s_wdata;
              MSTRB  <= s_strb;
              MSTART <= 1'b1;
              state  <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_queue.sv
// Directed self-checking bench for apb_req_queue.
// Drives CPU requests and bus completions, checks with assertions.
module tb_apb_req_queue;

  logic        PCLK;
  logic        PRESETn;
  logic        CREQ_VALID;
  logic        CREQ_READY;
  logic        CWRITE;
  logic [2:0]  CPROT;
  logic [31:0] CADDR;
  logic [31:0] CWDATA;
  logic [3:0]  CSTRB;
  logic        CRSP_VALID;
  logic        CRSP_WRITE;
  logic [31:0] CRDATA;
  logic        CSLVERR;
  logic        MSTART;
  logic        MWRITE;
  logic [2:0]  MPROT;
  logic [31:0] MADDR;
  logic [31:0] MWDATA;
  logic [3:0]  MSTRB;
  logic        MDONE;
  logic [31:0] MRDATA;
  logic        MSLVERR;
  logic [2:0]  COUNT;

  int nchk;
  int nerr;

  apb_req_queue dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .CREQ_VALID (CREQ_VALID),
    .CREQ_READY (CREQ_READY),
    .CWRITE     (CWRITE),
    .CPROT      (CPROT),
    .CADDR      (CADDR),
    .CWDATA     (CWDATA),
    .CSTRB      (CSTRB),
    .CRSP_VALID (CRSP_VALID),
    .CRSP_WRITE (CRSP_WRITE),
    .CRDATA     (CRDATA),
    .CSLVERR    (CSLVERR),
    .MSTART     (MSTART),
    .MWRITE     (MWRITE),
    .MPROT      (MPROT),
    .MADDR      (MADDR),
    .MWDATA     (MWDATA),
    .MSTRB      (MSTRB),
    .MDONE      (MDONE),
    .MRDATA     (MRDATA),
    .MSLVERR    (MSLVERR),
    .COUNT      (COUNT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] expv
  );
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(
    input logic        w,
    input logic [31:0] a,
    input logic [31:0] d
  );
    CREQ_VALID = 1'b1;
    CWRITE     = w;
    CADDR      = a;
    CWDATA     = d;
    CSTRB      = 4'hF;
    CPROT      = 3'd2;
    tick();
    CREQ_VALID = 1'b0;
  endtask

  task automatic done(
    input logic [31:0] d,
    input logic        e
  );
    MDONE   = 1'b1;
    MRDATA  = d;
    MSLVERR = e;
    tick();
    MDONE   = 1'b0;
    MRDATA  = '0;
    MSLVERR = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!MSTART && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", 64'(MSTART), 64'd1);
  endtask

  int          npushed;
  int          ndone;
  int          nstart;
  int          since;
  int          cyc;
  logic        drove_done;
  logic        acc;
  logic [31:0] exp_addr;

  initial begin
    nchk = 0;
    nerr = 0;
    PRESETn    = 1'b0;
    CREQ_VALID = 1'b0;
    CWRITE     = 1'b0;
    CPROT      = '0;
    CADDR      = '0;
    CWDATA     = '0;
    CSTRB      = '0;
    MDONE      = 1'b0;
    MRDATA     = '0;
    MSLVERR    = 1'b0;

    #3;
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_ready_low", 64'(CREQ_READY), 64'd0);
    #9 PRESETn = 1'b1;
    tick();
    chk("idle_count", 64'(COUNT), 64'd0);
    chk("idle_ready", 64'(CREQ_READY), 64'd1);
    chk("idle_mstart", 64'(MSTART), 64'd0);
    chk("idle_maddr", 64'(MADDR), 64'd0);
    chk("idle_mwdata", 64'(MWDATA), 64'd0);
    chk("idle_mwrite", 64'(MWRITE), 64'd0);
    chk("idle_mstrb", 64'(MSTRB), 64'd0);
    chk("idle_crsp", 64'(CRSP_VALID), 64'd0);

    // single write
    push(1'b1, 32'h10, 32'hDEADBEEF);
    chk("w_count", 64'(COUNT), 64'd1);
    chk("w_nostart", 64'(MSTART), 64'd0);
    tick();
    chk("w_mstart", 64'(MSTART), 64'd1);
    chk("w_maddr", 64'(MADDR), 64'h10);
    chk("w_mwdata", 64'(MWDATA), 64'hDEADBEEF);
    chk("w_mwrite", 64'(MWRITE), 64'd1);
    chk("w_mstrb", 64'(MSTRB), 64'hF);
    chk("w_mprot", 64'(MPROT), 64'd2);
    tick();
    chk("w_pulse_end", 64'(MSTART), 64'd0);
    tick();
    done(32'h5555AAAA, 1'b0);
    chk("w_rsp_valid", 64'(CRSP_VALID), 64'd1);
    chk("w_rsp_write", 64'(CRSP_WRITE), 64'd1);
    chk("w_rsp_data", 64'(CRDATA), 64'd0);
    chk("w_rsp_err", 64'(CSLVERR), 64'd0);
    chk("w_rsp_count", 64'(COUNT), 64'd0);
    tick();
    chk("w_rsp_pulse", 64'(CRSP_VALID), 64'd0);
    chk("w_rsp_hold", 64'(CRSP_WRITE), 64'd1);

    // single read with slave error
    push(1'b0, 32'h20, 32'h0);
    tick();
    chk("r_mstart", 64'(MSTART), 64'd1);
    chk("r_maddr", 64'(MADDR), 64'h20);
    chk("r_mwrite", 64'(MWRITE), 64'd0);
    tick();
    done(32'h12345678, 1'b1);
    chk("r_rsp_valid", 64'(CRSP_VALID), 64'd1);
    chk("r_rsp_data", 64'(CRDATA), 64'h12345678);
    chk("r_rsp_err", 64'(CSLVERR), 64'd1);
    chk("r_rsp_write", 64'(CRSP_WRITE), 64'd0);
    tick();
    chk("r_m_retain", 64'(MADDR), 64'h20);

    // MDONE in IDLE is ignored
    done(32'hFFFFFFFF, 1'b0);
    chk("idle_mdone", 64'(CRSP_VALID), 64'd0);
    chk("idle_mdone_data", 64'(CRDATA), 64'h12345678);

    // fill to full, stall the fifth
    push(1'b0, 32'h100, 32'h0);
    push(1'b0, 32'h104, 32'h0);
    push(1'b0, 32'h108, 32'h0);
    push(1'b0, 32'h10C, 32'h0);
    chk("full_count", 64'(COUNT), 64'd4);
    chk("full_ready", 64'(CREQ_READY), 64'd0);
    chk("full_head", 64'(MADDR), 64'h100);
    CREQ_VALID = 1'b1;
    CADDR      = 32'h200;
    CWRITE     = 1'b0;
    tick();
    tick();
    chk("stall_count", 64'(COUNT), 64'd4);
    done(32'hB0, 1'b0);
    chk("pop_rsp", 64'(CRSP_VALID), 64'd1);
    chk("pop_data", 64'(CRDATA), 64'hB0);
    chk("pop_count", 64'(COUNT), 64'd3);
    chk("pop_ready", 64'(CREQ_READY), 64'd1);
    chk("pop_mstart", 64'(MSTART), 64'd1);
    chk("pop_maddr", 64'(MADDR), 64'h104);
    tick();
    CREQ_VALID = 1'b0;
    chk("acc5_count", 64'(COUNT), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_start();
      tick();
      exp_addr = (k == 3) ? 32'h200 : 32'h104 + 32'(4 * k);
      chk("drain_addr", 64'(MADDR), 64'(exp_addr));
      done(32'hB1 + 32'(k), 1'b0);
      chk("drain_rsp", 64'(CRSP_VALID), 64'd1);
      chk("drain_data", 64'(CRDATA), 64'(32'hB1 + 32'(k)));
    end
    chk("drain_count", 64'(COUNT), 64'd0);

    // six back-to-back, MDONE two cycles after each MSTART
    npushed = 0;
    ndone   = 0;
    nstart  = 0;
    since   = -1;
    cyc     = 0;
    while (ndone < 6 && cyc < 200) begin
      if (npushed < 6) begin
        CREQ_VALID = 1'b1;
        CWRITE     = npushed[0];
        CADDR      = 32'h400 + 32'(4 * npushed);
        CWDATA     = 32'hC0 + 32'(npushed);
        CSTRB      = 4'hF;
      end else begin
        CREQ_VALID = 1'b0;
      end
      drove_done = (since == 2);
      MDONE      = drove_done;
      MRDATA     = 32'hA0000000 + 32'(ndone);
      acc        = CREQ_VALID & CREQ_READY;
      tick();
      cyc++;
      if (acc) npushed++;
      if (drove_done) begin
        chk("b2b_rsp", 64'(CRSP_VALID), 64'd1);
        chk("b2b_wr", 64'(CRSP_WRITE), 64'(ndone % 2));
        chk("b2b_data", 64'(CRDATA),
            (ndone % 2 == 1) ? 64'd0 :
            64'(32'hA0000000 + 32'(ndone)));
        ndone++;
        chk("b2b_restart", 64'(MSTART),
            64'(npushed > ndone));
        since = -1;
      end else if (since >= 0) begin
        since++;
      end
      if (MSTART) begin
        chk("b2b_order", 64'(MADDR),
            64'(32'h400 + 32'(4 * nstart)));
        nstart++;
        since = 0;
      end
    end
    MDONE      = 1'b0;
    CREQ_VALID = 1'b0;
    chk("b2b_all_done", 64'(ndone), 64'd6);
    chk("b2b_count", 64'(COUNT), 64'd0);

    // reset while waiting with three entries held
    push(1'b0, 32'h300, 32'h0);
    push(1'b0, 32'h304, 32'h0);
    push(1'b0, 32'h308, 32'h0);
    chk("pre_rst_count", 64'(COUNT), 64'd3);
    chk("pre_rst_maddr", 64'(MADDR), 64'h300);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_count", 64'(COUNT), 64'd0);
    chk("arst_maddr", 64'(MADDR), 64'd0);
    chk("arst_mstart", 64'(MSTART), 64'd0);
    chk("arst_crdata", 64'(CRDATA), 64'd0);
    chk("arst_ready", 64'(CREQ_READY), 64'd0);
    #2 PRESETn = 1'b1;
    tick();
    done(32'h77777777, 1'b1);
    chk("post_rst_rsp", 64'(CRSP_VALID), 64'd0);
    chk("post_rst_start", 64'(MSTART), 64'd0);
    chk("post_rst_count", 64'(COUNT), 64'd0);
    chk("post_rst_err", 64'(CSLVERR), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/apb_req_queue.md
Name: apb_req_queue

Overview:
- Upstream request buffer between the CPU (main master) and the APB protocol bus.
- Accepts CPU transactions over a valid/ready handshake and stores them in an in-order FIFO.
- Issues one transaction at a time to the bus's M* request interface, then returns read data and error status to the CPU as a one-cycle response pulse.
- Decouples the CPU from APB wait states and the two-phase APB protocol.

Parameters:
- ADDR_SIZE, 32, address width.
- DATA_SIZE, 32, data width.
- PROT_SIZE, 3, protection field width.
- STRB_SIZE, DATA_SIZE/8, write strobe width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived).

Ports:
- PCLK  in  1  clock; all logic is rising-edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- CREQ_VALID  in  1  CPU request valid.
- CREQ_READY  out  1  queue can accept a request.
- CWRITE  in  1  1 = write, 0 = read.
- CPROT  in  PROT_SIZE  protection.
- CADDR  in  ADDR_SIZE  address.
- CWDATA  in  DATA_SIZE  write data.
- CSTRB  in  STRB_SIZE  write strobes.
- CRSP_VALID  out  1  one-cycle response pulse.
- CRSP_WRITE  out  1  type of the completed transaction.
- CRDATA  out  DATA_SIZE  read data (0 for writes).
- CSLVERR  out  1  slave error of the completed transaction.
- MSTART  out  1  one-cycle pulse that starts a bus transfer.
- MWRITE  out  1  write/read to the bus.
- MPROT  out  PROT_SIZE  protection to the bus.
- MADDR  out  ADDR_SIZE  address to the bus.
- MWDATA  out  DATA_SIZE  write data to the bus.
- MSTRB  out  STRB_SIZE  strobes to the bus.
- MDONE  in  1  one-cycle pulse from the bus when a transfer completes.
- MRDATA  in  DATA_SIZE  read data from the bus, valid with MDONE.
- MSLVERR  in  1  slave error from the bus, valid with MDONE.
- COUNT  out  PTR_W+1  occupied entries.

Behaviour:
- Reset (PRESETn low, asynchronous):
  - State IDLE; read/write pointers 0; COUNT 0.
  - All registered outputs 0: MSTART, M*, CRSP_VALID, CRSP_WRITE, CRDATA, CSLVERR.
  - CREQ_READY = 1 whenever PRESETn is high and COUNT < DEPTH.
  - Reset mid-transfer discards all entries; no response is produced for them.
- Push:
  - Occurs on a rising edge when CREQ_VALID && CREQ_READY.
  - Stores {CWRITE, CPROT, CADDR, CWDATA, CSTRB} at the write pointer; write pointer increments mod DEPTH.
- CREQ_READY:
  - Derived from registered COUNT only (COUNT < DEPTH); there is no full-bypass.
  - A pop in the same cycle as full raises READY only on the next cycle.
- Simultaneous push and pop: COUNT is unchanged and both pointers advance.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if COUNT > 0, load M* from the head entry and go to ISSUE.
  - ISSUE: MSTART = 1 for exactly this cycle; go to WAIT.
  - WAIT:
    - M* outputs held stable.
    - On MDONE, pop the head (read pointer +1 mod DEPTH, COUNT -1).
    - Register CRSP_VALID = 1, CRSP_WRITE = MWRITE, CSLVERR = MSLVERR, and CRDATA = MWRITE ? 0 : MRDATA.
    - If entries remain after the pop, load the next head into M* and go to ISSUE; otherwise go to IDLE.
- M* outputs retain their last values in IDLE.
- Response outputs:
  - CRSP_VALID is high exactly one cycle, in the cycle after the MDONE edge.
  - CRDATA, CSLVERR and CRSP_WRITE hold their values until the next response.
- Latency:
  - Request accepted into an empty queue at edge t: MSTART is high in the cycle following edge t+1.
  - Back-to-back transfers: MSTART is high in the cycle following the edge that samples MDONE.
- MDONE sampled in IDLE or ISSUE is ignored.
- Responses are returned strictly in request order.

Decomposition:
- Shared package apb_pkg holds:
  - The state encoding localparams ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2.
  - The default ADDR/DATA/PROT sizes.
  - The request-entry width: 1 + PROT + ADDR + DATA + STRB.
- One sub-module, apb_sync_fifo, contains storage, pointers, COUNT, and full/empty logic. The FSM and the response path stay in apb_req_queue.

Test Plan:
- Reset -> COUNT = 0, CREQ_READY = 1, MSTART = 0, all M* = 0, CRSP_VALID = 0.
- Write CADDR = 0x10, CWDATA = 0xDEADBEEF, CSTRB = 0xF -> MSTART pulse with MADDR = 0x10, MWDATA = 0xDEADBEEF; MDONE with MSLVERR = 0 -> next cycle CRSP_VALID = 1, CRSP_WRITE = 1, CRDATA = 0, CSLVERR = 0.
- Read CADDR = 0x20; bridge returns MRDATA = 0x12345678 with MSLVERR = 1 -> CRDATA = 0x12345678, CSLVERR = 1, CRSP_WRITE = 0.
- Push 4 requests with MDONE withheld -> COUNT = 4, CREQ_READY = 0, 5th request stalls. One MDONE -> CREQ_READY = 1 the following cycle; 5th request is accepted; order is preserved.
- 6 back-to-back requests with MDONE two cycles after each MSTART -> pointers wrap; 6 responses in order; MSTART high in the cycle after each MDONE edge.
- PRESETn pulsed low in WAIT with COUNT = 3 -> outputs 0 immediately; COUNT = 0; a later MDONE produces no CRSP_VALID.
